// File: rtl/avl_addr_pio_if.sv
// avl_addr_pio_if: Avalon-MM slave bus bundle for avl_addr_pio.
// Word-addressed, zero-wait-state, combinational read data.
interface avl_addr_pio_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/avl_addr_pio.sv
// avl_addr_pio: Avalon-MM output port with bit set/clear and auto-increment.
// Optional wrap interrupt enabled by defining AVL_ADDR_PIO_IRQ_EN.
module avl_addr_pio #(
    parameter int          DATA_WIDTH  = 16,
    parameter logic [31:0] RESET_VALUE = 32'h0
) (
    input  logic                  clk,
    input  logic                  reset,
    avl_addr_pio_if.slave         bus,
    input  logic                  advance,
    output logic [DATA_WIDTH-1:0] out_port,
    output logic                  wrap_irq
);
    localparam int DW = DATA_WIDTH;

    localparam logic [2:0] A_DATA  = 3'd0;
    localparam logic [2:0] A_CTRL  = 3'd1;
    localparam logic [2:0] A_STEP  = 3'd2;
    localparam logic [2:0] A_LIMIT = 3'd3;
    localparam logic [2:0] A_SET   = 3'd4;
    localparam logic [2:0] A_CLR   = 3'd5;

    logic [DW-1:0] data_q, data_d;
    logic [DW-1:0] step_q, step_d;
    logic [DW-1:0] limit_q, limit_d;
    logic          auto_q, auto_d;
    logic          wrap_en_q, wrap_en_d;
    logic          irq_en_q, irq_en_d;
    logic          wrapped_q, wrapped_d;

    logic          we;
    logic [DW-1:0] wd;
    logic          data_wr;
    logic          adv_take;
    logic [DW:0]   sum;
    logic          wrap_act;
    logic [DW-1:0] adv_data;
    logic          adv_wrap;
    logic          unused_wd;

    assign we = bus.chipselect & ~bus.write_n;
    assign wd = bus.writedata[DW-1:0];
    assign unused_wd = ^bus.writedata;

    // Bus writes that touch DATA take priority and drop a same-cycle advance.
    assign data_wr = we & ((bus.address == A_DATA) |
                           (bus.address == A_SET)  |
                           (bus.address == A_CLR));
    assign adv_take = advance & auto_q & ~data_wr;

    // Step computation against the registered (old) CTRL/STEP/LIMIT.
    always_comb begin
        sum      = {1'b0, data_q} + {1'b0, step_q};
        wrap_act = wrap_en_q & (limit_q != '0);
        adv_data = sum[DW-1:0];
        adv_wrap = sum[DW];
        if (wrap_act) begin
            adv_wrap = (sum >= {1'b0, limit_q});
            adv_data = adv_wrap ? '0 : sum[DW-1:0];
        end
        if (step_q == '0) begin
            adv_data = data_q;
        end
    end

    // Next-state for all registers: bus write first, then advance.
    always_comb begin
        data_d    = data_q;
        step_d    = step_q;
        limit_d   = limit_q;
        auto_d    = auto_q;
        wrap_en_d = wrap_en_q;
        irq_en_d  = irq_en_q;
        wrapped_d = wrapped_q;
        if (we) begin
            case (bus.address)
                A_DATA:  data_d = wd;
                A_CTRL: begin
                    auto_d    = bus.writedata[0];
                    wrap_en_d = bus.writedata[1];
`ifdef AVL_ADDR_PIO_IRQ_EN
                    irq_en_d  = bus.writedata[2];
`endif
                    if (bus.writedata[8]) begin
                        wrapped_d = 1'b0;
                    end
                end
                A_STEP:  step_d  = wd;
                A_LIMIT: limit_d = wd;
                A_SET:   data_d  = data_q | wd;
                A_CLR:   data_d  = data_q & ~wd;
                default: ;
            endcase
        end
        if (adv_take) begin
            data_d = adv_data;
            if (adv_wrap) begin
                wrapped_d = 1'b1;
            end
        end
    end

    // Register state, asynchronously reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q    <= RESET_VALUE[DW-1:0];
            step_q    <= DW'(1);
            limit_q   <= '0;
            auto_q    <= 1'b0;
            wrap_en_q <= 1'b0;
            irq_en_q  <= 1'b0;
            wrapped_q <= 1'b0;
        end else begin
            data_q    <= data_d;
            step_q    <= step_d;
            limit_q   <= limit_d;
            auto_q    <= auto_d;
            wrap_en_q <= wrap_en_d;
            irq_en_q  <= irq_en_d;
            wrapped_q <= wrapped_d;
        end
    end

`ifdef AVL_ADDR_PIO_IRQ_EN
    logic irq_q;

    // Interrupt registered from next-state so it rises with WRAPPED.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= wrapped_d & irq_en_d;
        end
    end

    assign wrap_irq = irq_q;
`else
    assign wrap_irq = 1'b0;
`endif

    assign out_port = data_q;

    // Combinational read mux; write-only and reserved offsets read 0.
    always_comb begin
        bus.readdata = '0;
        case (bus.address)
            A_DATA:  bus.readdata = 32'(data_q);
            A_CTRL:  bus.readdata = {23'b0, wrapped_q, 5'b0,
                                     irq_en_q, wrap_en_q, auto_q};
            A_STEP:  bus.readdata = 32'(step_q);
            A_LIMIT: bus.readdata = 32'(limit_q);
            default: bus.readdata = '0;
        endcase
    end
endmodule
